// File: rtl/cache_arbiter_pkg.sv
// Shared definitions for the cache arbiter and the cache: request type codes, FSM states, request header.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Request type codes, identical to the encoding the cache decodes
    localparam logic [1:0] CACHE_READ    = 2'b00;
    localparam logic [1:0] CACHE_WRITE   = 2'b01;
    localparam logic [1:0] CACHE_FLUSH   = 2'b10;
    localparam logic [1:0] CACHE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10,
        ARB_RESP  = 2'b11
    } arb_state_e;

    // Latched request presented to the cache for the whole transaction
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
        logic [1:0]        typ;
    } req_hdr_t;

endpackage

// File: rtl/cache_arbiter_rr_arbiter.sv
// Combinational winner select over a request vector; round-robin from ptr, or fixed lowest-index priority when CACHE_ARB_FIXED_PRIO_EN is defined.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the winner is consumed.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    int cand;

    // Scan from the farthest candidate down so the first asserted request after the start point is the last one written
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(ptr) + k) % NUM_REQ;
`endif
            if (req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single-port data cache among NUM_REQ level requesters; CACHE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
// Latency: request to rq_done = 3 cycles + cache latency; illegal type completes in 2 cycles without touching the cache.
// Backpressure: one transaction in flight; losing requesters stay pending until granted, cache strobed only from ISSUE.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    rq_valid,
    input  logic [NUM_REQ*32-1:0] rq_addr,
    input  logic [NUM_REQ*32-1:0] rq_data,
    input  logic [NUM_REQ*2-1:0]  rq_type,
    output logic [NUM_REQ-1:0]    rq_done,
    output logic [31:0]           rq_rdata,
    output logic                  rq_err,
    output logic [31:0]           cache_req_addr,
    output logic [31:0]           cache_req_data,
    output logic [1:0]            cache_req_type,
    output logic                  cache_req_do,
    input  logic [31:0]           cache_O_data,
    input  logic                  cache_req_done
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [IDX_W-1:0]  gnt_idx_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;
    req_hdr_t          win_hdr;
    req_hdr_t          hdr_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (rq_valid),
        .ptr     (ptr_q),
        .gnt_idx (win_idx),
        .gnt_any (win_any)
    );

    // Unpack the winning requester's flat fields into one header
    always_comb begin
        win_hdr      = '0;
        win_hdr.addr = rq_addr[int'(win_idx)*32 +: 32];
        win_hdr.dat  = rq_data[int'(win_idx)*32 +: 32];
        win_hdr.typ  = rq_type[int'(win_idx)*2 +: 2];
    end

    // State register; reset aborts any transaction without a completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        state_d      = state_q;
        cache_req_do = 1'b0;
        rq_done      = '0;
        rq_rdata     = '0;
        rq_err       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (win_any) begin
                    state_d = (win_hdr.typ == CACHE_ILLEGAL) ? ARB_RESP : ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cache_req_do = 1'b1;
                state_d      = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cache_req_done) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                rq_done[gnt_idx_q] = 1'b1;
                rq_rdata           = rdata_q;
                rq_err             = err_q;
                state_d            = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant latch in IDLE, read-data capture in WAIT; done pulses outside WAIT have no effect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_idx_q <= '0;
            hdr_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (win_any) begin
                        gnt_idx_q <= win_idx;
                        hdr_q     <= win_hdr;
                        err_q     <= (win_hdr.typ == CACHE_ILLEGAL);
                        rdata_q   <= '0;
                    end
                end
                ARB_WAIT: begin
                    if (cache_req_done) begin
                        rdata_q <= (hdr_q.typ == CACHE_READ) ? cache_O_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    // Round-robin pointer moves past the requester just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (state_q == ARB_RESP) begin
            ptr_q <= (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
        end
    end
`endif

    assign cache_req_addr = hdr_q.addr;
    assign cache_req_data = hdr_q.dat;
    assign cache_req_type = hdr_q.typ;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus random requester/cache traffic against a transaction-level model.
// Latency: model expects strobe 1 cycle after grant, done 1 cycle after cache completion, illegal done 1 cycle after grant.
// Backpressure: bench cache model answers after a random 1..4 cycle delay, one request at a time.
`timescale 1ns/1ps
module tb_cache_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      rq_valid;
    logic [N*32-1:0]   rq_addr;
    logic [N*32-1:0]   rq_data;
    logic [N*2-1:0]    rq_type;
    logic [N-1:0]      rq_done;
    logic [31:0]       rq_rdata;
    logic              rq_err;
    logic [31:0]       cache_req_addr;
    logic [31:0]       cache_req_data;
    logic [1:0]        cache_req_type;
    logic              cache_req_do;
    logic [31:0]       cache_O_data;
    logic              cache_req_done;

    cache_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rq_valid       (rq_valid),
        .rq_addr        (rq_addr),
        .rq_data        (rq_data),
        .rq_type        (rq_type),
        .rq_done        (rq_done),
        .rq_rdata       (rq_rdata),
        .rq_err         (rq_err),
        .cache_req_addr (cache_req_addr),
        .cache_req_data (cache_req_data),
        .cache_req_type (cache_req_type),
        .cache_req_do   (cache_req_do),
        .cache_O_data   (cache_O_data),
        .cache_req_done (cache_req_done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [N-1:0] pend;
    logic [31:0]  a_m [N];
    logic [31:0]  d_m [N];
    logic [1:0]   t_m [N];
    int           ptr_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            rq_valid[i]          = pend[i];
            rq_addr[32*i +: 32]  = a_m[i];
            rq_data[32*i +: 32]  = d_m[i];
            rq_type[2*i +: 2]    = t_m[i];
        end
    endtask

    // Winner rule: first pending requester at or after the pointer, wrapping
    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        pend[i] = 1'b1;
        a_m[i]  = a;
        d_m[i]  = d;
        t_m[i]  = t;
    endtask

    // One arbitration opportunity; entered just after a negedge with the DUT idle
    task automatic do_round(input int lat, input logic [31:0] cd, input bit spur, input bit viol, output int w);
        logic [31:0] ea;
        logic [31:0] ed;
        logic [1:0]  et;
        check_eq("idle_do", 64'(cache_req_do), 64'd0);
        check_eq("idle_done", 64'(rq_done), 64'd0);
        drive_reqs();
        w = pick(pend, ptr_m);
        if (w < 0) begin
            cache_req_done = spur;
            @(negedge clk);
            cache_req_done = 1'b0;
            return;
        end
        ea = a_m[w];
        ed = d_m[w];
        et = t_m[w];
        @(negedge clk);
        if (et == 2'b11) begin
            check_eq("ill_do", 64'(cache_req_do), 64'd0);
            check_eq("ill_done", 64'(rq_done), 64'(1) << w);
            check_eq("ill_err", 64'(rq_err), 64'd1);
            check_eq("ill_rdata", 64'(rq_rdata), 64'd0);
        end else begin
            check_eq("issue_do", 64'(cache_req_do), 64'd1);
            check_eq("issue_addr", 64'(cache_req_addr), 64'(ea));
            check_eq("issue_data", 64'(cache_req_data), 64'(ed));
            check_eq("issue_type", 64'(cache_req_type), 64'(et));
            check_eq("issue_done", 64'(rq_done), 64'd0);
            cache_req_done = spur;
            cache_O_data   = $urandom;
            for (int j = 1; j <= lat; j++) begin
                @(negedge clk);
                cache_req_done = 1'b0;
                check_eq("wait_do", 64'(cache_req_do), 64'd0);
                check_eq("wait_addr", 64'(cache_req_addr), 64'(ea));
                check_eq("wait_data", 64'(cache_req_data), 64'(ed));
                check_eq("wait_type", 64'(cache_req_type), 64'(et));
                check_eq("wait_done", 64'(rq_done), 64'd0);
                if (viol && j == 1) begin
                    pend[w] = 1'b0;
                    drive_reqs();
                end
                if (j == lat) begin
                    cache_req_done = 1'b1;
                    cache_O_data   = cd;
                end
            end
            @(negedge clk);
            cache_req_done = 1'b0;
            cache_O_data   = $urandom;
            check_eq("resp_done", 64'(rq_done), 64'(1) << w);
            check_eq("resp_err", 64'(rq_err), 64'd0);
            check_eq("resp_rdata", 64'(rq_rdata), (et == 2'b00) ? 64'(cd) : 64'd0);
            check_eq("resp_do", 64'(cache_req_do), 64'd0);
        end
        pend[w] = 1'b0;
        drive_reqs();
`ifndef CACHE_ARB_FIXED_PRIO_EN
        ptr_m = (w + 1) % N;
`endif
        @(negedge clk);
    endtask

    // Reset asserted while a read waits on the cache; no completion may appear
    task automatic reset_mid_wait();
        pend = '0;
        set_req(0, 32'h0000_0200, 32'h0, 2'b00);
        drive_reqs();
        @(negedge clk);
        check_eq("rst_issue_do", 64'(cache_req_do), 64'd1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("rst_do", 64'(cache_req_do), 64'd0);
        check_eq("rst_done", 64'(rq_done), 64'd0);
        check_eq("rst_err", 64'(rq_err), 64'd0);
        check_eq("rst_rdata", 64'(rq_rdata), 64'd0);
        check_eq("rst_addr", 64'(cache_req_addr), 64'd0);
        check_eq("rst_data", 64'(cache_req_data), 64'd0);
        check_eq("rst_type", 64'(cache_req_type), 64'd0);
        pend = '0;
        drive_reqs();
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_hold_done", 64'(rq_done), 64'd0);
        end
        reset = 1'b1;
        ptr_m = 0;
    endtask

    initial begin
        int w;
        int r;
        pend           = '0;
        rq_valid       = '0;
        rq_addr        = '0;
        rq_data        = '0;
        rq_type        = '0;
        cache_O_data   = '0;
        cache_req_done = 1'b0;
        ptr_m          = 0;
        for (int i = 0; i < N; i++) begin
            a_m[i] = '0;
            d_m[i] = '0;
            t_m[i] = '0;
        end
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_do", 64'(cache_req_do), 64'd0);
        check_eq("reset_done", 64'(rq_done), 64'd0);
        check_eq("reset_err", 64'(rq_err), 64'd0);
        check_eq("reset_rdata", 64'(rq_rdata), 64'd0);
        check_eq("reset_addr", 64'(cache_req_addr), 64'd0);
        check_eq("reset_data", 64'(cache_req_data), 64'd0);
        check_eq("reset_type", 64'(cache_req_type), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Contention: req0 and req1 held, pointer at 0
        set_req(0, 32'h0000_1000, 32'h0, 2'b00);
        set_req(1, 32'h0000_2000, 32'h0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            do_round(2, $urandom, 1'b0, 1'b0, w);
`ifdef CACHE_ARB_FIXED_PRIO_EN
            check_eq("contend_grant", 64'(w), 64'd0);
`else
            check_eq("contend_grant", 64'(w), 64'(k % 2));
`endif
            pend[w] = 1'b1;
        end
        pend[0] = 1'b0;
        do_round(1, $urandom, 1'b0, 1'b0, w);
        check_eq("contend_after_drop", 64'(w), 64'd1);

        // Single read, cache answers after 4 cycles
        set_req(0, 32'h0000_0104, 32'h0, 2'b00);
        do_round(4, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
        check_eq("read_grant", 64'(w), 64'd0);

        // Write from req1, spurious cache done during ISSUE must be ignored
        set_req(1, 32'h0000_0300, 32'h1234_5678, 2'b01);
        do_round(3, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
        check_eq("write_grant", 64'(w), 64'd1);

        // Illegal type on req0
        set_req(0, 32'h0000_0400, 32'h0, 2'b11);
        do_round(1, 32'h0, 1'b0, 1'b0, w);

        // Reset during WAIT, then a fresh read
        reset_mid_wait();
        set_req(0, 32'h0000_0500, 32'h0, 2'b00);
        do_round(2, 32'hCAFE_F00D, 1'b0, 1'b0, w);
        check_eq("post_reset_grant", 64'(w), 64'd0);

        // Random traffic
        repeat (200) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    r = int'($urandom_range(0, 9));
                    set_req(i, $urandom, $urandom, (r == 0) ? 2'b11 : 2'(r % 3));
                end
            end
            do_round(int'($urandom_range(1, 4)), $urandom, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 19) == 0, w);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
